sfx_scheduler: RTL and testbench

//  Arbitrates one-cycle sound-effect requests from game logic and plays each effect as a fixed note

---
 rtl/sfx_pkg.sv | 49 ++++
 rtl/sfx_tone_gen.sv | 27 ++
 rtl/sfx_scheduler.sv | 131 +++++++++++++
 tb/tb_sfx_scheduler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// Shared definitions for the sound-effect scheduler: effect ids, FSM encoding,
// note entry layout and the effect ROM.
package sfx_pkg;

  localparam int HP_W = 20;

  localparam logic [1:0] SFX_PADDLE      = 2'd0;
  localparam logic [1:0] SFX_BLOCK_HIT   = 2'd1;
  localparam logic [1:0] SFX_LEVEL_CLEAR = 2'd2;
  localparam logic [1:0] SFX_GAME_OVER   = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef struct packed {
    logic            last;
    logic [HP_W-1:0] hp;
  } note_t;

  // Half-periods in clk cycles; hp==0 is a rest. Unused slots read as a terminating rest.
  function automatic note_t sfx_note(input logic [1:0] id, input logic [1:0] idx);
    note_t n;
    case ({id, idx})
      {SFX_PADDLE,      2'd0}: n = '{1'b1, 20'd40000};
      {SFX_BLOCK_HIT,   2'd0}: n = '{1'b0, 20'd30000};
      {SFX_BLOCK_HIT,   2'd1}: n = '{1'b1, 20'd25000};
      {SFX_LEVEL_CLEAR, 2'd0}: n = '{1'b0, 20'd40000};
      {SFX_LEVEL_CLEAR, 2'd1}: n = '{1'b0, 20'd35000};
      {SFX_LEVEL_CLEAR, 2'd2}: n = '{1'b0, 20'd30000};
      {SFX_LEVEL_CLEAR, 2'd3}: n = '{1'b1, 20'd25000};
      {SFX_GAME_OVER,   2'd0}: n = '{1'b0, 20'd50000};
      {SFX_GAME_OVER,   2'd1}: n = '{1'b0, 20'd0};
      {SFX_GAME_OVER,   2'd2}: n = '{1'b1, 20'd60000};
      default:                 n = '{1'b1, 20'd0};
    endcase
    return n;
  endfunction

  function automatic logic [1:0] hi_id(input logic [3:0] v);
    logic [1:0] id;
    if (v[3])      id = 2'd3;
    else if (v[2]) id = 2'd2;
    else if (v[1]) id = 2'd1;
    else           id = 2'd0;
    return id;
  endfunction

endpackage

// File: rtl/sfx_tone_gen.sv
// Square-wave generator: toggles beep_raw every hp cycles; load restarts the
// note low with a cleared counter, hp==0 holds the output silent.
module sfx_tone_gen
  import sfx_pkg::*;
(
  input  logic            clk,
  input  logic            RST,
  input  logic            load,
  input  logic [HP_W-1:0] hp,
  output logic            beep_raw
);

  logic [HP_W-1:0] hp_cnt_reg;

  always_ff @(posedge clk) begin
    if (RST || load || (hp == '0)) begin
      hp_cnt_reg <= '0;
      beep_raw   <= 1'b0;
    end else if (hp_cnt_reg == hp - HP_W'(1)) begin
      hp_cnt_reg <= '0;
      beep_raw   <= ~beep_raw;
    end else begin
      hp_cnt_reg <= hp_cnt_reg + HP_W'(1);
    end
  end

endmodule

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: latches request pulses, grants the highest pending
// effect and sequences its notes. Define SFX_PREEMPT_EN to let a higher effect abort the current one.
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int NOTE_CYC = 2_500_000,
  parameter int GAP_CYC  = 250_000,
  parameter int HP_SHIFT = 0
) (
  input  logic       clk,
  input  logic       RST,
  input  logic [3:0] req,
  input  logic       mute,
  output logic [3:0] ack,
  output logic       busy,
  output logic [1:0] cur_sfx,
  output logic       beep
);

  localparam int CNT_MAX = (NOTE_CYC > GAP_CYC) ? NOTE_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [1:0]       state_reg, state_next;
  logic [3:0]       pending_reg, pending_next;
  logic [3:0]       ack_reg, ack_next;
  logic [3:0]       grant_mask;
  logic [1:0]       cur_sfx_reg, cur_sfx_next;
  logic [1:0]       note_idx_reg, note_idx_next;
  logic [CNT_W-1:0] dur_cnt_reg, dur_cnt_next;
  logic             load;
  logic             do_grant;
  logic [1:0]       win_id;
  note_t            cur_note;
  logic [HP_W-1:0]  hp_play;
  logic             beep_raw;

  assign cur_note = sfx_note(cur_sfx_reg, note_idx_reg);
  assign win_id   = hi_id(pending_reg);

`ifdef SFX_PREEMPT_EN
  assign do_grant = (pending_reg != 4'd0) &&
                    ((state_reg == ST_IDLE) || (win_id > cur_sfx_reg));
`else
  assign do_grant = (state_reg == ST_IDLE) && (pending_reg != 4'd0);
`endif

  // Repeat pulses of an id already pending collapse into a single replay.
  for (genvar gi = 0; gi < 4; gi++) begin : g_pend
    assign pending_next[gi] = (pending_reg[gi] | req[gi]) & ~grant_mask[gi];
  end

  always_comb begin
    state_next    = state_reg;
    cur_sfx_next  = cur_sfx_reg;
    note_idx_next = note_idx_reg;
    dur_cnt_next  = dur_cnt_reg;
    ack_next      = 4'd0;
    grant_mask    = 4'd0;
    load          = 1'b0;
    case (state_reg)
      ST_IDLE: ;
      ST_PLAY: begin
        if (dur_cnt_reg == CNT_W'(NOTE_CYC - 1)) begin
          state_next   = ST_GAP;
          dur_cnt_next = '0;
        end else begin
          dur_cnt_next = dur_cnt_reg + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (dur_cnt_reg == CNT_W'(GAP_CYC - 1)) begin
          dur_cnt_next = '0;
          if (cur_note.last) begin
            state_next = ST_IDLE;
          end else begin
            note_idx_next = note_idx_reg + 2'd1;
            state_next    = ST_PLAY;
            load          = 1'b1;
          end
        end else begin
          dur_cnt_next = dur_cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // A grant (fresh or preempting) overrides whatever the sequencer chose.
    if (do_grant) begin
      state_next    = ST_PLAY;
      cur_sfx_next  = win_id;
      note_idx_next = 2'd0;
      dur_cnt_next  = '0;
      ack_next      = 4'd1 << win_id;
      grant_mask    = 4'd1 << win_id;
      load          = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_reg    <= ST_IDLE;
      pending_reg  <= 4'd0;
      ack_reg      <= 4'd0;
      cur_sfx_reg  <= 2'd0;
      note_idx_reg <= 2'd0;
      dur_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      pending_reg  <= pending_next;
      ack_reg      <= ack_next;
      cur_sfx_reg  <= cur_sfx_next;
      note_idx_reg <= note_idx_next;
      dur_cnt_reg  <= dur_cnt_next;
    end
  end

  assign hp_play = (state_reg == ST_PLAY) ? (cur_note.hp >> HP_SHIFT) : '0;

  sfx_tone_gen u_tone (
    .clk      (clk),
    .RST      (RST),
    .load     (load),
    .hp       (hp_play),
    .beep_raw (beep_raw)
  );

  assign ack     = ack_reg;
  assign busy    = (state_reg != ST_IDLE);
  assign cur_sfx = cur_sfx_reg;
  assign beep    = beep_raw & (state_reg == ST_PLAY) & ~mute;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed bench for sfx_scheduler with an ack scoreboard and a per-cycle beep/busy model.
module tb_sfx_scheduler;

  localparam int NOTE = 100;
  localparam int GAP  = 10;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       mute = 1'b0;
  logic [3:0] req = 4'd0;
  logic [3:0] ack;
  logic       busy;
  logic [1:0] cur_sfx;
  logic       beep;

  sfx_scheduler #(.NOTE_CYC(NOTE), .GAP_CYC(GAP), .HP_SHIFT(10)) dut (
    .clk     (clk),
    .RST     (RST),
    .req     (req),
    .mute    (mute),
    .ack     (ack),
    .busy    (busy),
    .cur_sfx (cur_sfx),
    .beep    (beep)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int ack_seen = 0;
  int last_ack_cyc = 0;
  int t_req = 0;
  int t_idle = 0;
  logic [3:0] exp_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Scoreboard consumer: every ack pulse must match the next expected grant.
  always @(posedge clk) begin
    logic [3:0] e;
    #2;
    if (ack !== 4'd0) begin
      ack_seen++;
      last_ack_cyc = cyc;
      $display("tb: ack=%b cur_sfx=%0d at cycle %0d", ack, cur_sfx, cyc);
      if (exp_q.size() == 0) begin
        chk("ack_unexpected", 32'(ack), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ack_order", 32'(ack), 32'(e));
      end
    end
  end

  task automatic pulse_req(input logic [3:0] r);
    req = r;
    t_req = cyc;
    @(negedge clk);
    req = 4'd0;
  endtask

  task automatic wait_ack(input int budget, input string tag);
    int prev;
    bit ok;
    prev = ack_seen;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ack_seen != prev) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_ack_seen"}, 32'(ok), 32'd1);
  endtask

  // One note: NOTE tone cycles then GAP silent cycles, busy high throughout.
  task automatic check_note(input int h, input bit muted, input logic [3:0] inj,
                            input int npulse, input string tag);
    int bad_beep = 0;
    int bad_busy = 0;
    logic e;
    for (int k = 1; k <= NOTE + GAP; k++) begin
      req = ((k % 2 == 1) && (k < 2 * npulse)) ? inj : 4'd0;
      e = (k <= NOTE && h != 0 && !muted) ? (((k - 1) / h) % 2 == 1) : 1'b0;
      if (beep !== e) bad_beep++;
      if (busy !== 1'b1) bad_busy++;
      @(negedge clk);
    end
    req = 4'd0;
    chk({tag, "_beep_errs"}, 32'(bad_beep), 32'd0);
    chk({tag, "_busy_errs"}, 32'(bad_busy), 32'd0);
  endtask

  task automatic check_effect(input int n, input int h0, input int h1, input int h2,
                              input int h3, input bit muted, input string tag);
    int hs[4];
    hs = '{h0, h1, h2, h3};
    for (int i = 0; i < n; i++)
      check_note(hs[i], muted, 4'd0, 0, $sformatf("%s_n%0d", tag, i));
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    t_idle = cyc;
  endtask

  initial begin
    int seen_before;
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen_before;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cur_sfx", 32'(cur_sfx), 32'd0);
    chk("rst_beep", 32'(beep), 32'd0);
    RST = 1'b0;
    @(negedge clk);

    // 1: paddle effect, single note of hp 39
    exp_q.push_back(4'b0001);
    pulse_req(4'b0001);
    wait_ack(5, "t1");
    chk("t1_latency", 32'(last_ack_cyc - t_req), 32'd2);
    chk("t1_cur_sfx", 32'(cur_sfx), 32'd0);
    check_effect(1, 39, 0, 0, 0, 1'b0, "t1");
    repeat (3) @(negedge clk);

    // 2: simultaneous game-over and block-hit; game over first, then block hit back-to-back
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0010);
    pulse_req(4'b1010);
    wait_ack(5, "t2a");
    chk("t2_cur_sfx_a", 32'(cur_sfx), 32'd3);
    check_effect(3, 48, 0, 58, 0, 1'b0, "t2a");
    wait_ack(3, "t2b");
    chk("t2_regrant_gap", 32'(last_ack_cyc - t_idle), 32'd1);
    chk("t2_cur_sfx_b", 32'(cur_sfx), 32'd1);
    check_effect(2, 29, 24, 0, 0, 1'b0, "t2b");
    repeat (3) @(negedge clk);

    // 3: game-over requested while level-clear is on its second note
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    pulse_req(4'b0100);
    wait_ack(5, "t3a");
    check_note(39, 1'b0, 4'd0, 0, "t3_n0");
`ifdef SFX_PREEMPT_EN
    pulse_req(4'b1000);
    wait_ack(4, "t3b");
    chk("t3_preempt_latency", 32'(last_ack_cyc - t_req), 32'd2);
    chk("t3_preempt_beep", 32'(beep), 32'd0);
`else
    check_note(34, 1'b0, 4'b1000, 1, "t3_n1");
    check_note(29, 1'b0, 4'd0, 0, "t3_n2");
    check_note(24, 1'b0, 4'd0, 0, "t3_n3");
    chk("t3_idle_busy", 32'(busy), 32'd0);
    t_idle = cyc;
    wait_ack(3, "t3b");
    chk("t3_regrant_gap", 32'(last_ack_cyc - t_idle), 32'd1);
`endif
    chk("t3_cur_sfx", 32'(cur_sfx), 32'd3);
    check_effect(3, 48, 0, 58, 0, 1'b0, "t3c");
    repeat (3) @(negedge clk);

    // 4: muted block-hit, timing unchanged
    mute = 1'b1;
    exp_q.push_back(4'b0010);
    pulse_req(4'b0010);
    wait_ack(5, "t4");
    chk("t4_latency", 32'(last_ack_cyc - t_req), 32'd2);
    check_effect(2, 29, 24, 0, 0, 1'b1, "t4");
    mute = 1'b0;
    repeat (3) @(negedge clk);

    // 5: reset mid-note with other requests pending
    exp_q.push_back(4'b0100);
    pulse_req(4'b0100);
    wait_ack(5, "t5");
    repeat (4) @(negedge clk);
    pulse_req(4'b0110);
    repeat (44) @(negedge clk);
    chk("t5_pre_rst_beep", 32'(beep), 32'd1);
    RST = 1'b1;
    @(negedge clk);
    chk("t5_rst_ack", 32'(ack), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_cur_sfx", 32'(cur_sfx), 32'd0);
    chk("t5_rst_beep", 32'(beep), 32'd0);
    RST = 1'b0;
    seen_before = ack_seen;
    repeat (40) @(negedge clk);
    chk("t5_no_late_ack", 32'(ack_seen - seen_before), 32'd0);
    chk("t5_idle_busy", 32'(busy), 32'd0);

    // 6: three repeat requests during block-hit produce exactly one replay
    exp_q.push_back(4'b0010);
    pulse_req(4'b0010);
    wait_ack(5, "t6a");
    exp_q.push_back(4'b0010);
    check_note(29, 1'b0, 4'b0010, 3, "t6_n0");
    check_note(24, 1'b0, 4'd0, 0, "t6_n1");
    chk("t6_idle_busy", 32'(busy), 32'd0);
    t_idle = cyc;
    wait_ack(3, "t6b");
    chk("t6_regrant_gap", 32'(last_ack_cyc - t_idle), 32'd1);
    seen_before = ack_seen;
    check_effect(2, 29, 24, 0, 0, 1'b0, "t6b");
    repeat (30) @(negedge clk);
    chk("t6_single_replay", 32'(ack_seen - seen_before), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
